// File: rtl/ray_gen_pkg.sv
// Shared fixed-point and vec3 types, add helpers and default screen resolution
// for the primary-ray generator.
package ray_gen_pkg;

  localparam int unsigned FIXED_W      = 32;
  localparam int unsigned SCREEN_H_RES = 320;
  localparam int unsigned SCREEN_V_RES = 180;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Two's-complement wrapping add; camera setup keeps sums in range.
  function automatic fixed_t fixed_add(input fixed_t a, input fixed_t b);
    return FIXED_W'(a + b);
  endfunction

  function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
    vec3_t r;
    r.x = fixed_add(a.x, b.x);
    r.y = fixed_add(a.y, b.y);
    r.z = fixed_add(a.z, b.z);
    return r;
  endfunction

endpackage

// File: rtl/ray_gen.sv
// Primary-ray direction generator: walks the frame in raster order and emits one
// unnormalized direction per pixel, built incrementally from a latched camera basis.
module ray_gen
  import ray_gen_pkg::*;
#(
  parameter int unsigned H_RES = SCREEN_H_RES,
  parameter int unsigned V_RES = SCREEN_V_RES
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  input  vec3_t                    base_in,
  input  vec3_t                    step_x_in,
  input  vec3_t                    step_y_in,
  input  logic                     ready_in,
  output logic                     valid_out,
  output vec3_t                    dir_out,
  output logic [$clog2(H_RES)-1:0] hcount_out,
  output logic [$clog2(V_RES)-1:0] vcount_out,
  output logic                     last_out,
  output logic                     busy_out
);

  localparam int unsigned HW = $clog2(H_RES);
  localparam int unsigned VW = $clog2(V_RES);

  state_e state_q;
  state_e state_d;

  vec3_t step_x_q;
  vec3_t step_y_q;
  vec3_t row_base_q;
  vec3_t row_next;

  logic handshake;
  logic h_end;
  logic v_end;

  assign handshake = valid_out && ready_in;
  assign h_end     = (hcount_out == HW'(H_RES - 1));
  assign v_end     = (vcount_out == VW'(V_RES - 1));
  assign row_next  = vec3_add(row_base_q, step_y_q);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_RUN;
      S_RUN:   if (handshake && h_end && v_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; valid/busy come straight from the state flop
  always_comb begin
    valid_out = (state_q == S_RUN);
    busy_out  = (state_q == S_RUN);
    last_out  = (state_q == S_RUN) && h_end && v_end;
  end

  // Datapath: basis latch, incremental direction and raster counters
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      step_x_q   <= '0;
      step_y_q   <= '0;
      row_base_q <= '0;
      dir_out    <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            step_x_q   <= step_x_in;
            step_y_q   <= step_y_in;
            row_base_q <= base_in;
            dir_out    <= base_in;
            hcount_out <= '0;
            vcount_out <= '0;
          end
        end
        S_RUN: begin
          if (handshake) begin
            if (!h_end) begin
              dir_out    <= vec3_add(dir_out, step_x_q);
              hcount_out <= hcount_out + HW'(1);
            end else if (!v_end) begin
              row_base_q <= row_next;
              dir_out    <= row_next;
              hcount_out <= '0;
              vcount_out <= vcount_out + VW'(1);
            end else begin
              // Final pixel: direction holds, counters rewind for the next frame
              hcount_out <= '0;
              vcount_out <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen with a scoreboard of expected beats computed from
// the closed form base + h*step_x + v*step_y.
module tb_ray_gen;
  import ray_gen_pkg::*;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned HW = $clog2(H);
  localparam int unsigned VW = $clog2(V);
  localparam int          CYCLE_BUDGET = 200;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start_in = 1'b0;
  vec3_t         base_in = '0;
  vec3_t         step_x_in = '0;
  vec3_t         step_y_in = '0;
  logic          ready_in = 1'b1;
  logic          valid_out;
  vec3_t         dir_out;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          last_out;
  logic          busy_out;

  typedef struct {
    vec3_t dir;
    int    h;
    int    v;
    logic  last;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass   = 0;
  int    n_checks = 0;

  ray_gen #(.H_RES(H), .V_RES(V)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .start_in   (start_in),
    .base_in    (base_in),
    .step_x_in  (step_x_in),
    .step_y_in  (step_y_in),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .dir_out    (dir_out),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .last_out   (last_out),
    .busy_out   (busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec3_t mk(input int x, input int y, input int z);
    vec3_t r;
    r.x = fixed_t'(x);
    r.y = fixed_t'(y);
    r.z = fixed_t'(z);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic push_frame(input vec3_t b, input vec3_t sx, input vec3_t sy);
    beat_t e;
    for (int v = 0; v < int'(V); v++) begin
      for (int h = 0; h < int'(H); h++) begin
        e.dir.x = b.x + fixed_t'(h) * sx.x + fixed_t'(v) * sy.x;
        e.dir.y = b.y + fixed_t'(h) * sx.y + fixed_t'(v) * sy.y;
        e.dir.z = b.z + fixed_t'(h) * sx.z + fixed_t'(v) * sy.z;
        e.h     = h;
        e.v     = v;
        e.last  = (h == int'(H) - 1) && (v == int'(V) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_beat();
    beat_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("dir_x", dir_out.x, e.dir.x);
    check("dir_y", dir_out.y, e.dir.y);
    check("dir_z", dir_out.z, e.dir.z);
    check("hcount", 32'(hcount_out), 32'(e.h));
    check("vcount", 32'(vcount_out), 32'(e.v));
    check("last", 32'(last_out), 32'(e.last));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_last"}, 32'(last_out), 32'd0);
    check({tag, "_h"}, 32'(hcount_out), 32'd0);
    check({tag, "_v"}, 32'(vcount_out), 32'd0);
  endtask

  // Drive one frame from a negedge; abort_at >= 0 asserts reset after that many beats.
  task automatic run_frame(input vec3_t b, input vec3_t sx, input vec3_t sy,
                           input bit rand_rdy, input bit repulse, input int abort_at);
    int         beats = 0;
    int         cycles = 0;
    bit         stalled = 1'b0;
    bit         rdy;
    vec3_t      snap_dir;
    logic [31:0] snap_h, snap_v, snap_last;

    start_in  = 1'b1;
    base_in   = b;
    step_x_in = sx;
    step_y_in = sy;
    push_frame(b, sx, sy);
    @(negedge clk_in);
    start_in  = 1'b0;
    base_in   = mk(777, 777, 777);
    step_x_in = mk(5, 5, 5);
    step_y_in = mk(9, 9, 9);
    check("busy_after_start", 32'(busy_out), 32'd1);

    while (beats < int'(H * V) && cycles < CYCLE_BUDGET) begin
      if (abort_at >= 0 && beats == abort_at) begin
        #2 rst_n_in = 1'b0;
        #1;
        check_zero("abort");
        check("abort_dir_x", dir_out.x, 32'd0);
        check("abort_dir_z", dir_out.z, 32'd0);
        exp_q.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        return;
      end
      if (stalled) begin
        check("stall_dir_x", dir_out.x, snap_dir.x);
        check("stall_dir_y", dir_out.y, snap_dir.y);
        check("stall_dir_z", dir_out.z, snap_dir.z);
        check("stall_h", 32'(hcount_out), snap_h);
        check("stall_v", 32'(vcount_out), snap_v);
        check("stall_last", 32'(last_out), snap_last);
      end
      rdy      = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_in = rdy;
      start_in = repulse && (beats == 2);
      base_in  = mk(-5000, 4000, 3);
      check("valid_held", 32'(valid_out), 32'd1);
      if (rdy) begin
        check_beat();
        beats++;
        stalled = 1'b0;
      end else begin
        snap_dir  = dir_out;
        snap_h    = 32'(hcount_out);
        snap_v    = 32'(vcount_out);
        snap_last = 32'(last_out);
        stalled   = 1'b1;
      end
      @(negedge clk_in);
      cycles++;
    end
    start_in = 1'b0;
    ready_in = 1'b1;
    check("frame_beats", 32'(beats), 32'(H * V));
    check_zero("frame_end");
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec3_t b0, sx0, sy0;
    b0  = mk(0, 0, 1000);
    sx0 = mk(10, 0, 0);
    sy0 = mk(0, -10, 0);

    // Reset, then idle with ready high
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    check("rst_dir_x", dir_out.x, 32'd0);
    check("rst_dir_y", dir_out.y, 32'd0);
    check("rst_dir_z", dir_out.z, 32'd0);
    for (int i = 0; i < 20; i++) begin
      check_zero("idle");
      @(negedge clk_in);
    end

    // Full-rate frame
    run_frame(b0, sx0, sy0, 1'b0, 1'b0, -1);
    @(negedge clk_in);

    // Random backpressure
    run_frame(b0, sx0, sy0, 1'b1, 1'b0, -1);
    @(negedge clk_in);

    // Back-to-back frame with start re-pulsed mid-frame
    run_frame(b0, sx0, sy0, 1'b1, 1'b1, -1);

    // Asynchronous reset after three beats, then a clean restart
    @(negedge clk_in);
    run_frame(b0, sx0, sy0, 1'b0, 1'b0, 3);
    check_zero("post_abort");
    @(negedge clk_in);
    run_frame(b0, sx0, sy0, 1'b0, 1'b0, -1);
    @(negedge clk_in);

    // Two's-complement wrap on x
    run_frame(mk(32'h7fff_ffff, 0, 1000), mk(1, 0, 0), sy0, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ray_gen.md
# ray_gen

Primary-ray direction generator for the raytracer pipeline. On a start pulse it walks the frame in raster order. For each pixel it emits one unnormalized direction `vec3`, with that pixel's coordinates, over a valid/ready handshake to `vec3_normalize` directly downstream. Directions are built incrementally from a latched camera basis using only `vec3` adds, with no multipliers, at one pixel per cycle when downstream is ready.

## Interface
- `H_RES`, 320, pixels per row (≥2)
- `V_RES`, 180, rows per frame (≥2)
- `clk_in`  input  1  system clock; single clock domain
- `rst_n_in`  input  1  reset, asynchronous, active-low
- `start_in`  input  1  frame start pulse; honoured only in IDLE
- `base_in`  input  vec3  direction through pixel (0,0); latched on accepted start
- `step_x_in`  input  vec3  per-column direction increment; latched on accepted start
- `step_y_in`  input  vec3  per-row direction increment; latched on accepted start
- `ready_in`  input  1  downstream can accept
- `valid_out`  output  1  `dir_out`/`hcount_out`/`vcount_out`/`last_out` valid
- `dir_out`  output  vec3  unnormalized ray direction
- `hcount_out`  output  $clog2(H_RES)  pixel column
- `vcount_out`  output  $clog2(V_RES)  pixel row
- `last_out`  output  1  high with the final pixel (H_RES-1, V_RES-1)
- `busy_out`  output  1  high from accepted start until final handshake

## Operation
- States: IDLE, RUN.
- IDLE:
  - `start_in`=1 latches `base_in`, `step_x_in` and `step_y_in`.
  - Loads `dir_out`=`row_base`=`base`, counters=0.
  - Raises `valid_out` and `busy_out`, then enters RUN.
- RUN: a handshake is `valid_out && ready_in`. On each handshake:
  - Not at end of row: `dir_out` += `step_x`, `hcount_out`++.
  - End of row, not last: `row_base` += `step_y`, `dir_out` = `row_base` + `step_y`, `hcount_out`=0, `vcount_out`++.
  - Last pixel: `valid_out`, `busy_out` and `last_out` drop, counters return to 0, state returns to IDLE. `dir_out` holds its value.
- Arithmetic: component-wise `vec3` add using the `fixed` adder. Two's-complement wrap, no saturation. Camera setup must keep sums in range.
- `last_out` is combinational from the counters, qualified by `valid_out`.
- `start_in` during RUN is ignored. Latched basis registers do not change mid-frame.
- Reset (any time, including mid-frame):
  - State goes to IDLE.
  - `valid_out`, `busy_out` and `last_out` go to 0.
  - `dir_out`, `row_base`, basis registers and counters go to 0.
  - Downstream must treat the dropped frame as aborted.

## Timing
- Start to first valid: 1 cycle. `start_in` sampled at edge N gives `valid_out`=1 after edge N.
- Throughput: 1 pixel/cycle with `ready_in` held high. A frame is `H_RES*V_RES` handshakes.
- Stall: while `valid_out && !ready_in`, all outputs hold exactly.
- `valid_out` never depends combinationally on `ready_in`. It does not drop until its handshake.
- Back-to-back frames: the earliest new start is the cycle after the last handshake (in IDLE). The minimum inter-frame gap is 1 cycle.
- Start and a final handshake in the same cycle: start is ignored, because the block is in RUN.

## Structure
- `vec3`, `fixed` and their add helpers come from the existing shared headers (`types.sv`, `fixed.sv`, `vec3.sv`).
- Default screen-resolution constants (`SCREEN_H_RES`, `SCREEN_V_RES`) go in `types.sv`, and both parameters default to them.
- No sub-module. A single always_ff with a small FSM plus registered adders.

## Test plan
All values are raw fixed LSBs. Parameters are H_RES=4, V_RES=2. Basis is base=(0,0,1000), step_x=(10,0,0), step_y=(0,-10,0).
- Reset then idle, `ready_in`=1: all outputs 0, `busy_out`=0 for 20 cycles.
- Start pulse, `ready_in`=1:
  - 8 consecutive valids with x components 0,10,20,30,0,10,20,30.
  - y components 0×4 then -10×4; z always 1000.
  - Counters (0,0)…(3,1), `last_out` only on the 8th valid, then `busy_out`=0.
- Same frame with `ready_in` randomly toggled: identical 8-beat sequence, outputs stable across every stall cycle.
- Start re-pulsed mid-frame with a different base: ignored, sequence unchanged.
- Assert `rst_n_in`=0 asynchronously at beat 3: outputs 0 immediately. After release, a new start begins again at (0,0) with base.
- Wrap: base x=max positive fixed, step_x=1. The second beat x equals the most negative fixed.
